mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// CPU-side memory access controller: latches one request, decodes it to ROM or RAM,
// sequences the memory strobes and returns a single-cycle ready/err completion.
module mem_access_ctrl #(
  parameter int ROM_WAIT = 2,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic [11:0]       dec_addr,
  input  logic              rom_sel,
  input  logic              ram_sel,
  output logic [11:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rom_oe,
  output logic              ram_ce,
  output logic              ram_we
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ROM_RD,
    RAM_ACC,
    DONE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ROM_WAIT - 1);

  state_e              state_q, state_d;
  logic [11:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    // NOTE: every next-state value defaults to its current register first, so no
    // path through the case statement can leave a signal unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (rom_sel && !ram_sel) begin
          if (we_q) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ROM_RD;
          end
        end else if (ram_sel && !rom_sel) begin
          state_d = RAM_ACC;
        end else begin
          // Neither or both selects asserted: decoder fault, complete with error.
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      ROM_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RAM_ACC: begin
        if (!we_q) rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them immediately.
  assign rdata     = rdata_q;
  assign ready     = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign busy      = (state_q != IDLE);
  assign dec_addr  = addr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rom_oe    = (state_q == ROM_RD);
  assign ram_ce    = (state_q == RAM_ACC);
  assign ram_we    = (state_q == RAM_ACC) && we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single accesses against a small
// ROM/RAM model, plus hand-written busy-ignore and mid-access reset sequences.
module tb_mem_access_ctrl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [11:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic [11:0]       dec_addr;
  logic              rom_sel;
  logic              ram_sel;
  logic [11:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rom_oe;
  logic              ram_ce;
  logic              ram_we;

  int checks   = 0;
  int failures = 0;

  // Decoder and memory model; the decode can be overridden to inject faults.
  logic              force_en  = 1'b0;
  logic              force_rom = 1'b0;
  logic              force_ram = 1'b0;
  logic [DATA_W-1:0] rom_data  = '0;
  logic [DATA_W-1:0] ram_mem [16];

  assign rom_sel   = force_en ? force_rom : ~dec_addr[11];
  assign ram_sel   = force_en ? force_ram :  dec_addr[11];
  assign mem_rdata = ram_ce ? ram_mem[mem_addr[3:0]] : rom_data;

  always @(posedge clk) if (ram_ce && ram_we) ram_mem[mem_addr[3:0]] <= mem_wdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ROM_WAIT(2), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy), .dec_addr(dec_addr),
    .rom_sel(rom_sel), .ram_sel(ram_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rom_oe(rom_oe), .ram_ce(ram_ce), .ram_we(ram_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       we;
    logic [11:0] addr;
    logic [7:0] wdata;
    logic [7:0] rom_data;
    logic       force_en;
    logic       force_rom;
    logic       force_ram;
    int         exp_lat;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_rom_cyc;
    int         exp_ram_cyc;
    int         exp_ramwe_cyc;
  } vec_t;

  vec_t vecs [10];

  // Issue one request for a single accept edge, then observe every cycle up to ready.
  task automatic run_access(input vec_t v);
    int  lat, rom_cyc, ram_cyc, ramwe_cyc;
    bit  seen, busy_ok, addr_ok, excl_ok;
    logic got_err;
    force_en  = v.force_en;
    force_rom = v.force_rom;
    force_ram = v.force_ram;
    rom_data  = v.rom_data;
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req = 1'b0; addr = ~v.addr; wdata = ~v.wdata; we = ~v.we;
    lat = 0; rom_cyc = 0; ram_cyc = 0; ramwe_cyc = 0;
    seen = 1'b0; busy_ok = 1'b1; addr_ok = 1'b1; excl_ok = 1'b1; got_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      lat = c;
      if (!busy) busy_ok = 1'b0;
      if (mem_addr !== v.addr || dec_addr !== v.addr) addr_ok = 1'b0;
      if ((rom_oe && ram_ce) || (ram_we && !ram_ce)) excl_ok = 1'b0;
      if (rom_oe) rom_cyc++;
      if (ram_ce) ram_cyc++;
      if (ram_we) ramwe_cyc++;
      if (ready) begin
        seen    = 1'b1;
        got_err = err;
        break;
      end
      @(negedge clk);
    end
    check({v.name, " ready seen"},   32'(seen),      32'd1);
    check({v.name, " latency"},      32'(lat),       32'(v.exp_lat));
    check({v.name, " err"},          32'(got_err),   32'(v.exp_err));
    check({v.name, " rdata"},        32'(rdata),     32'(v.exp_rdata));
    check({v.name, " rom_oe cyc"},   32'(rom_cyc),   32'(v.exp_rom_cyc));
    check({v.name, " ram_ce cyc"},   32'(ram_cyc),   32'(v.exp_ram_cyc));
    check({v.name, " ram_we cyc"},   32'(ramwe_cyc), 32'(v.exp_ramwe_cyc));
    check({v.name, " busy held"},    32'(busy_ok),   32'd1);
    check({v.name, " addr stable"},  32'(addr_ok),   32'd1);
    check({v.name, " strobe rules"}, 32'(excl_ok),   32'd1);
  endtask

  initial begin
    vec_t v;
    int   accepts;
    bit   stable_ok, ready_seen;
    logic [11:0] drv_addr;

    //          name        we   addr     wd     rom    fe   fr   fm   lat err rdata  rom ram rwe
    vecs[0] = '{"ram_wr1",  1'b1, 12'h805, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h00, 0, 1, 1};
    vecs[1] = '{"ram_rd1",  1'b0, 12'h805, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'hA5, 0, 1, 0};
    vecs[2] = '{"rom_rd1",  1'b0, 12'h010, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h3C, 2, 0, 0};
    vecs[3] = '{"rom_wr",   1'b1, 12'h020, 8'h77, 8'h99, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h3C, 0, 0, 0};
    vecs[4] = '{"ram_wr2",  1'b1, 12'h8FF, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h3C, 0, 1, 1};
    vecs[5] = '{"ram_rd2",  1'b0, 12'h8FF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h5A, 0, 1, 0};
    vecs[6] = '{"rom_rd2",  1'b0, 12'h7FF, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'hC3, 2, 0, 0};
    vecs[7] = '{"ram_rd3",  1'b0, 12'h805, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'hA5, 0, 1, 0};
    vecs[8] = '{"dec_none", 1'b0, 12'h810, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 0, 0, 0};
    vecs[9] = '{"dec_both", 1'b0, 12'h010, 8'h00, 8'h22, 1'b1, 1'b1, 1'b1, 2, 1'b1, 8'hA5, 0, 0, 0};

    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy",   32'(busy),     32'd0);
    check("reset ready",  32'(ready),    32'd0);
    check("reset err",    32'(err),      32'd0);
    check("reset rdata",  32'(rdata),    32'd0);
    check("reset addr",   32'(mem_addr), 32'd0);
    check("reset strobe", 32'({rom_oe, ram_ce, ram_we}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_access(vecs[i]);
    force_en = 1'b0;

    // Busy ignore: req held high with a changing address through a ROM read.
    rom_data = 8'h4D;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 12'h010;
    stable_ok = 1'b1; ready_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy && mem_addr !== 12'h010) stable_ok = 1'b0;
      if (ready) begin
        ready_seen = 1'b1;
        break;
      end
      addr = 12'h0A0 + 12'(c);
    end
    check("hold ready seen",   32'(ready_seen), 32'd1);
    check("hold addr stable",  32'(stable_ok),  32'd1);
    check("hold rdata",        32'(rdata),      32'h4D);
    drv_addr = 12'h0F0;
    addr = drv_addr;
    @(negedge clk);
    check("hold idle visit", 32'(busy), 32'd0);
    drv_addr = 12'h0F1;
    addr = drv_addr;
    @(negedge clk);
    check("hold reaccept busy", 32'(busy),     32'd1);
    check("hold reaccept addr", 32'(mem_addr), 32'(drv_addr));
    req = 1'b0;
    accepts = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      if (ready) accepts++;
      @(negedge clk);
    end
    check("hold single done", 32'(accepts), 32'd1);

    // Reset during the second ROM_RD cycle.
    rom_data = 8'hE1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 12'h030;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid rom_oe before", 32'(rom_oe), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid rom_oe after", 32'(rom_oe), 32'd0);
    check("mid busy after",   32'(busy),   32'd0);
    check("mid rdata reset",  32'(rdata),  32'd0);
    ready_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready) ready_seen = 1'b1;
    end
    check("mid no ready", 32'(ready_seen), 32'd0);
    rst_n = 1'b1;
    check("mid addr reset", 32'(dec_addr), 32'd0);
    v = vecs[7];
    v.name = "post_rst_rd";
    run_access(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
